cpu_out_checker: RTL and testbench

Parametrised, synthesizable self-checking monitor for CPU result buses. It watches a CPU's `out` port, detects each new result value and compares it in order against an expected-value queue loaded beforehand. It reports pass, fail or timeout with cycle and match counts. It sits beside the single-cycle and pipelined CPU tops in benches and on-board bring-up, replacing fixed-duration, eyeball-checked runs.

---
 rtl/cpu_out_checker_pkg.sv | 15 +
 rtl/cpu_out_checker_fifo.sv | 55 +++++
 rtl/cpu_out_checker.sv | 164 ++++++++++++++++
 tb/tb_cpu_out_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_out_checker_pkg.sv
// Shared definitions for the CPU result checker: checker state encoding and
// the default datapath width.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TOUT = 3'd4
    } chk_state_t;

endpackage

// File: rtl/cpu_out_checker_fifo.sv
// Expected-value queue for cpu_out_checker: DEPTH x DATA_W, push/pop/flush,
// wrapping pointers one bit wider than the address.
module chk_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic              last,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Full when pointers differ only in the wrap bit.
    assign full  = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign empty = (wr_ptr == rd_ptr);
    assign last  = ((wr_ptr - rd_ptr) == PTR_ONE);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cpu_out_checker.sv
// Self-checking monitor for a CPU result bus: compares each new result against
// a preloaded queue. Optional capture of the first mismatch: CPU_CHECKER_CAPTURE_EN.
module cpu_out_checker
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   exp_we,
    input  logic [DATA_W-1:0]      exp_wdata,
    output logic                   exp_full,
    input  logic                   start,
    input  logic                   dut_valid,
    input  logic [DATA_W-1:0]      dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [$clog2(DEPTH):0] match_cnt,
    output logic [31:0]            cycle_cnt,
    output logic [DATA_W-1:0]      fail_got,
    output logic [DATA_W-1:0]      fail_exp
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   TO_LAST = 32'(TIMEOUT - 1);

    chk_state_t        state;
    chk_state_t        nxt;
    logic              first;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_empty;
    logic              fifo_last;
    logic              arm;
    logic              cap_fail;
    logic              cap_tout;
    logic              ev;
    logic              hit;
    logic              to_hit;

    chk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (exp_wdata),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .full  (exp_full),
        .empty (fifo_empty),
        .last  (fifo_last),
        .head  (head)
    );

    assign ev     = dut_valid && (first || (dut_out != prev));
    assign hit    = (dut_out == head);
    assign to_hit = (TIMEOUT != 0) && (cycle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        arm        = 1'b0;
        cap_fail   = 1'b0;
        cap_tout   = 1'b0;
        case (state)
            IDLE: begin
                fifo_push = exp_we;
                if (start) begin
                    if (fifo_empty) begin
                        nxt = PASS;
                    end else begin
                        nxt = RUN;
                        arm = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ev && hit) begin
                    fifo_pop = 1'b1;
                    if (fifo_last) nxt = PASS;
                end else if (ev) begin
                    nxt      = FAIL;
                    cap_fail = 1'b1;
                end
                // Timeout only fires when no verdict was reached this cycle.
                if (nxt == RUN && to_hit) begin
                    nxt      = TOUT;
                    cap_tout = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    nxt        = IDLE;
                    fifo_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first     <= 1'b0;
            prev      <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
        end else if (fifo_flush) begin
            first     <= 1'b0;
            prev      <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if (arm) begin
                first <= 1'b1;
            end else if (state == RUN && ev) begin
                first <= 1'b0;
                prev  <= dut_out;
            end
            if (fifo_pop) match_cnt <= match_cnt + CNT_ONE;
            if (state == RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == PASS) || (state == FAIL) || (state == TOUT);
    assign pass = (state == PASS);

`ifdef CPU_CHECKER_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_got <= '0;
            fail_exp <= '0;
        end else if (fifo_flush) begin
            fail_got <= '0;
            fail_exp <= '0;
        end else if (cap_fail) begin
            fail_got <= dut_out;
            fail_exp <= head;
        end else if (cap_tout) begin
            fail_got <= prev;
            fail_exp <= head;
        end
    end
`else
    assign fail_got = '0;
    assign fail_exp = '0;
`endif

endmodule

// File: tb/tb_cpu_out_checker.sv
// Directed bench for cpu_out_checker: default-parameter instance plus a
// TIMEOUT=8 instance sharing the same stimulus.
module tb_cpu_out_checker;

`ifdef CPU_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic        start;
    logic        dut_valid;
    logic [15:0] dut_out;

    logic        exp_full,   busy,   done,   pass;
    logic [4:0]  match_cnt;
    logic [31:0] cycle_cnt;
    logic [15:0] fail_got,   fail_exp;

    logic        t_exp_full, t_busy, t_done, t_pass;
    logic [4:0]  t_match_cnt;
    logic [31:0] t_cycle_cnt;
    logic [15:0] t_fail_got, t_fail_exp;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_out_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .exp_we    (exp_we),
        .exp_wdata (exp_wdata),
        .exp_full  (exp_full),
        .start     (start),
        .dut_valid (dut_valid),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .match_cnt (match_cnt),
        .cycle_cnt (cycle_cnt),
        .fail_got  (fail_got),
        .fail_exp  (fail_exp)
    );

    cpu_out_checker #(.TIMEOUT(8)) dut_to (
        .clk       (clk),
        .rst_n     (rst_n),
        .exp_we    (exp_we),
        .exp_wdata (exp_wdata),
        .exp_full  (t_exp_full),
        .start     (start),
        .dut_valid (dut_valid),
        .dut_out   (dut_out),
        .busy      (t_busy),
        .done      (t_done),
        .pass      (t_pass),
        .match_cnt (t_match_cnt),
        .cycle_cnt (t_cycle_cnt),
        .fail_got  (t_fail_got),
        .fail_exp  (t_fail_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_we    = 1'b0;
        exp_wdata = '0;
        start     = 1'b0;
        dut_valid = 1'b0;
        dut_out   = '0;
        rst_n     = 1'b0;
        #3;
        rst_n     = 1'b1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_we    = 1'b1;
        exp_wdata = v;
        tick();
        exp_we    = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [15:0] v);
        dut_valid = 1'b1;
        dut_out   = v;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        #1;

        // reset values
        check_eq("rst_busy",  {31'd0, busy},  0);
        check_eq("rst_done",  {31'd0, done},  0);
        check_eq("rst_full",  {31'd0, exp_full}, 0);
        check_eq("rst_match", {27'd0, match_cnt}, 0);
        check_eq("rst_cycle", cycle_cnt, 0);

        // first sample 0x0000 mismatches the head 0x0005
        push(16'h0005); push(16'h000A); push(16'h000F);
        arm();
        check_eq("t1_busy", {31'd0, busy}, 1);
        drive(16'h0000);
        check_eq("t1_done",  {31'd0, done}, 1);
        check_eq("t1_pass",  {31'd0, pass}, 0);
        check_eq("t1_busy0", {31'd0, busy}, 0);
        check_eq("t1_cycle", cycle_cnt, 1);
        check_eq("t1_got",   {16'd0, fail_got}, 0);
        check_eq("t1_exp",   {16'd0, fail_exp}, CAP ? 32'h5 : 32'h0);
        drive(16'h0005); drive(16'h0005); drive(16'h000A); drive(16'h000F);
        check_eq("t1_hold_done",  {31'd0, done}, 1);
        check_eq("t1_hold_match", {27'd0, match_cnt}, 0);
        check_eq("t1_hold_cycle", cycle_cnt, 1);

        // duplicates collapse to one event
        do_reset();
        push(16'h0005); push(16'h000A); push(16'h000F);
        arm();
        drive(16'h0005); drive(16'h0005); drive(16'h000A);
        check_eq("t2_mid_done",  {31'd0, done}, 0);
        check_eq("t2_mid_match", {27'd0, match_cnt}, 2);
        drive(16'h000F);
        check_eq("t2_done",  {31'd0, done}, 1);
        check_eq("t2_pass",  {31'd0, pass}, 1);
        check_eq("t2_match", {27'd0, match_cnt}, 3);
        check_eq("t2_cycle", cycle_cnt, 4);
        drive(16'h0001);
        check_eq("t2_hold_pass",  {31'd0, pass}, 1);
        check_eq("t2_hold_cycle", cycle_cnt, 4);

        // timeout after exactly 8 RUN cycles on the TIMEOUT=8 instance
        do_reset();
        push(16'h1234);
        arm();
        dut_valid = 1'b0;
        dut_out   = 16'h0000;
        for (int i = 0; i < 7; i++) tick();
        check_eq("t3_busy7",  {31'd0, t_busy}, 1);
        check_eq("t3_cycle7", t_cycle_cnt, 7);
        tick();
        check_eq("t3_done",  {31'd0, t_done}, 1);
        check_eq("t3_pass",  {31'd0, t_pass}, 0);
        check_eq("t3_busy",  {31'd0, t_busy}, 0);
        check_eq("t3_cycle", t_cycle_cnt, 8);
        check_eq("t3_exp",   {16'd0, t_fail_exp}, CAP ? 32'h1234 : 32'h0);
        check_eq("t3_nodef_busy", {31'd0, busy}, 1);

        // overfill: 17th push dropped, 16 matches pass
        do_reset();
        for (int i = 1; i <= 15; i++) push(16'(i));
        check_eq("t4_full15", {31'd0, exp_full}, 0);
        push(16'd16);
        check_eq("t4_full16", {31'd0, exp_full}, 1);
        push(16'h0099);
        check_eq("t4_full17", {31'd0, exp_full}, 1);
        arm();
        for (int i = 1; i <= 16; i++) drive(16'(i));
        check_eq("t4_pass",  {31'd0, pass}, 1);
        check_eq("t4_match", {27'd0, match_cnt}, 16);
        check_eq("t4_cycle", cycle_cnt, 16);
        check_eq("t4_full",  {31'd0, exp_full}, 0);

        // asynchronous reset mid-RUN, then a fresh run
        do_reset();
        push(16'h0005); push(16'h000A); push(16'h000F);
        arm();
        drive(16'h0005); drive(16'h000A);
        check_eq("t5_match2", {27'd0, match_cnt}, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy",  {31'd0, busy}, 0);
        check_eq("t5_done",  {31'd0, done}, 0);
        check_eq("t5_match", {27'd0, match_cnt}, 0);
        check_eq("t5_cycle", cycle_cnt, 0);
        rst_n = 1'b1;
        dut_valid = 1'b0;
        tick();
        push(16'h0007); push(16'h0008);
        arm();
        drive(16'h0007); drive(16'h0008);
        check_eq("t5_pass",  {31'd0, pass}, 1);
        check_eq("t5_match_new", {27'd0, match_cnt}, 2);

        // empty-queue start passes immediately; re-arm returns to IDLE
        do_reset();
        arm();
        check_eq("t6_pass",  {31'd0, pass}, 1);
        check_eq("t6_match", {27'd0, match_cnt}, 0);
        check_eq("t6_busy",  {31'd0, busy}, 0);
        arm();
        check_eq("t6_done",  {31'd0, done}, 0);
        check_eq("t6_pass0", {31'd0, pass}, 0);
        check_eq("t6_busy0", {31'd0, busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
